spi_fifo: RTL and testbench

Synchronous single-clock FIFO for the SPI APB data path, instantiated twice in the SPI data block: as the transmit FIFO (APB write side feeds, shift engine drains) and as the receive FIFO (shift engine fills, APB read side drains). Data appears at the output as soon as it is stored (first-word-fall-through, FWFT), so the shift engine can load the next word without a read-latency bubble. The block reports fill level and full/empty/overflow/underflow status to the SPI controller's status and interrupt registers.

---
 rtl/spi_package.sv | 19 +
 rtl/spi_fifo_mem.sv | 35 +++
 rtl/spi_fifo.sv | 111 +++++++++++
 tb/tb_spi_fifo.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_package.sv
// spi_package: shared constants and types for the SPI APB data path.
//   SPI_DATA_WIDTH    - word width carried through the TX/RX FIFOs.
//   SPI_POINTER_WIDTH - FIFO address bits; depth is 2**SPI_POINTER_WIDTH.
//   SPI_FIFO_DEPTH    - number of words per FIFO.
//   fifo_interrupt    - FIFO status bundle reported to the controller.
package spi_package;

    localparam int SPI_DATA_WIDTH    = 32;
    localparam int SPI_POINTER_WIDTH = 6;
    localparam int SPI_FIFO_DEPTH    = 2 ** SPI_POINTER_WIDTH;

    typedef struct packed {
        logic fifo_full;
        logic fifo_empty;
        logic fifo_overflow;
        logic fifo_underflow;
    } fifo_interrupt;

endpackage : spi_package

// File: rtl/spi_fifo_mem.sv
// spi_fifo_mem: storage array for spi_fifo.
//   pclk   in  clock; writes land on the rising edge
//   wen    in  write enable (already qualified by the FIFO control)
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address
//   rdata  out read data, asynchronous from the array
module spi_fifo_mem #(
    parameter int DATA_WIDTH    = 32,
    parameter int POINTER_WIDTH = 6
) (
    input  logic                     pclk,
    input  logic                     wen,
    input  logic [POINTER_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [POINTER_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    localparam int DEPTH = 2 ** POINTER_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: storage arrays carry no reset; the pointers alone decide which
    // entries are meaningful, and a reset here would block RAM mapping.
    always_ff @(posedge pclk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read gives first-word-fall-through at the FIFO level.
    assign rdata = mem[raddr];

endmodule : spi_fifo_mem

// File: rtl/spi_fifo.sv
// spi_fifo: single-clock first-word-fall-through FIFO used for the SPI
// transmit and receive data paths.
//   pclk    in  clock; all state changes on the rising edge
//   preset  in  synchronous active-high reset
//   clear   in  synchronous flush, priority over wen/ren
//   wen     in  push request
//   wdata   in  push data
//   ren     in  pop request
//   rdata   out head word, valid while status.fifo_empty = 0
//   level   out number of stored words (0..2**POINTER_WIDTH)
//   status  out {fifo_full, fifo_empty, fifo_overflow, fifo_underflow};
//               full/empty are combinational from the pointers, the
//               overflow/underflow pulses are registered.
module spi_fifo
    import spi_package::*;
#(
    parameter int DATA_WIDTH    = SPI_DATA_WIDTH,
    parameter int POINTER_WIDTH = SPI_POINTER_WIDTH
) (
    input  logic                   pclk,
    input  logic                   preset,
    input  logic                   clear,
    input  logic                   wen,
    input  logic [DATA_WIDTH-1:0]  wdata,
    input  logic                   ren,
    output logic [DATA_WIDTH-1:0]  rdata,
    output logic [POINTER_WIDTH:0] level,
    output fifo_interrupt          status
);

    localparam logic [POINTER_WIDTH:0] PTR_ONE = {{POINTER_WIDTH{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [POINTER_WIDTH:0] wptr;
    logic [POINTER_WIDTH:0] rptr;
    logic                   overflow_q;
    logic                   underflow_q;

    logic empty;
    logic full;
    logic flush;
    logic do_push;
    logic do_pop;
    logic overflow_d;
    logic underflow_d;

    assign empty = (wptr == rptr);
    assign full  = (wptr[POINTER_WIDTH] != rptr[POINTER_WIDTH]) &&
                   (wptr[POINTER_WIDTH-1:0] == rptr[POINTER_WIDTH-1:0]);
    assign flush = preset | clear;

    // NOTE: every signal driven here gets a default first so no latch is
    // inferred on paths that do not assign it.
    always_comb begin
        do_push     = 1'b0;
        do_pop      = 1'b0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (!flush) begin
            do_pop      = ren && !empty;
            // A pop in the same cycle frees the slot a full FIFO needs.
            do_push     = wen && (!full || ren);
            overflow_d  = wen && full && !ren;
            underflow_d = ren && empty;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge pclk) begin
        if (flush) begin
            wptr        <= '0;
            rptr        <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (do_pop) begin
                rptr <= rptr + PTR_ONE;
            end
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // When full with push+pop, waddr equals raddr: the old head is read
    // this cycle and overwritten at the edge as rptr moves past it.
    spi_fifo_mem #(
        .DATA_WIDTH    (DATA_WIDTH),
        .POINTER_WIDTH (POINTER_WIDTH)
    ) u_mem (
        .pclk  (pclk),
        .wen   (do_push),
        .waddr (wptr[POINTER_WIDTH-1:0]),
        .wdata (wdata),
        .raddr (rptr[POINTER_WIDTH-1:0]),
        .rdata (rdata)
    );

    assign level = wptr - rptr;

    always_comb begin
        status.fifo_full      = full;
        status.fifo_empty     = empty;
        status.fifo_overflow  = overflow_q;
        status.fifo_underflow = underflow_q;
    end

endmodule : spi_fifo

// File: tb/tb_spi_fifo.sv
// Self-checking bench for spi_fifo against a queue-based reference model.
module tb_spi_fifo;
    import spi_package::*;

    localparam int DW    = SPI_DATA_WIDTH;
    localparam int DEPTH = SPI_FIFO_DEPTH;

    logic          pclk = 1'b0;
    logic          preset;
    logic          clear;
    logic          wen;
    logic          ren;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic [6:0]    level;
    fifo_interrupt status;

    spi_fifo dut (
        .pclk   (pclk),
        .preset (preset),
        .clear  (clear),
        .wen    (wen),
        .wdata  (wdata),
        .ren    (ren),
        .rdata  (rdata),
        .level  (level),
        .status (status)
    );

    always #5 pclk = ~pclk;

    // Reference model: the FIFO contents as a queue plus the expected pulses.
    logic [DW-1:0] q[$];
    bit            exp_ovf;
    bit            exp_unf;
    int            n_checks = 0;
    int            n_pass   = 0;

    // Apply one cycle of requests, advance the model, return 1ns after the edge.
    task automatic step(input bit w, input bit r, input logic [DW-1:0] d,
                        input bit c, input bit p);
        int sz;
        wen = w; ren = r; wdata = d; clear = c; preset = p;
        sz = q.size();
        if (c || p) begin
            q.delete();
            exp_ovf = 0;
            exp_unf = 0;
        end else begin
            exp_unf = r && (sz == 0);
            exp_ovf = w && (sz == DEPTH) && !r;
            if (r && sz > 0) void'(q.pop_front());
            if (w && !exp_ovf) q.push_back(d);
        end
        @(posedge pclk);
        #1;
        wen = 0; ren = 0; clear = 0; preset = 0;
    endtask

    function automatic logic [10:0] exp_flags();
        int sz = q.size();
        return {7'(sz), sz == DEPTH, sz == 0, exp_ovf, exp_unf};
    endfunction

    task automatic test_reset();
        step(0, 0, '0, 0, 1);
        step(0, 0, '0, 0, 0);
        n_checks++;
        if ({level, status} !== 11'b0000000_0100)
            $display("FAIL reset_state: got level=%0d status=%b want level=0 status=0100", level, status);
        else n_pass++;
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= DEPTH; i++) step(1, 0, DW'(i), 0, 0);
        n_checks++;
        if (level !== 7'd64 || status.fifo_full !== 1'b1)
            $display("FAIL fill_full: got level=%0d full=%b want 64/1", level, status.fifo_full);
        else n_pass++;
        step(1, 0, 32'hDEADBEEF, 0, 0);
        n_checks++;
        if (status.fifo_overflow !== 1'b1 || level !== 7'd64)
            $display("FAIL overflow_pulse: got ovf=%b level=%0d want 1/64", status.fifo_overflow, level);
        else n_pass++;
        step(0, 0, '0, 0, 0);
        n_checks++;
        if (status.fifo_overflow !== 1'b0)
            $display("FAIL overflow_one_cycle: got ovf=%b want 0", status.fifo_overflow);
        else n_pass++;
        for (int i = 1; i <= DEPTH; i++) begin
            n_checks++;
            if (rdata !== DW'(i))
                $display("FAIL drain_order[%0d]: got %h want %h", i, rdata, DW'(i));
            else n_pass++;
            step(0, 1, '0, 0, 0);
        end
        n_checks++;
        if ({level, status} !== 11'b0000000_0100)
            $display("FAIL drained_empty: got level=%0d status=%b want 0/0100", level, status);
        else n_pass++;
    endtask

    task automatic test_fwft_underflow();
        step(1, 0, 32'hA5A5A5A5, 0, 0);
        n_checks++;
        if (rdata !== 32'hA5A5A5A5 || status.fifo_empty !== 1'b0)
            $display("FAIL fwft: got rdata=%h empty=%b want a5a5a5a5/0", rdata, status.fifo_empty);
        else n_pass++;
        step(0, 1, '0, 0, 0);
        step(0, 1, '0, 0, 0);
        n_checks++;
        if (status.fifo_underflow !== 1'b1 || level !== 7'd0)
            $display("FAIL underflow_pulse: got unf=%b level=%0d want 1/0", status.fifo_underflow, level);
        else n_pass++;
        step(0, 0, '0, 0, 0);
        n_checks++;
        if (status.fifo_underflow !== 1'b0)
            $display("FAIL underflow_one_cycle: got unf=%b want 0", status.fifo_underflow);
        else n_pass++;
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < DEPTH; i++) step(1, 0, $urandom, 0, 0);
        step(1, 1, 32'h12345678, 0, 0);
        n_checks++;
        if (level !== 7'd64 || status.fifo_overflow !== 1'b0 || rdata !== q[0])
            $display("FAIL full_push_pop: got level=%0d ovf=%b rdata=%h want 64/0/%h",
                     level, status.fifo_overflow, rdata, q[0]);
        else n_pass++;
        for (int i = 0; i < DEPTH - 1; i++) begin
            n_checks++;
            if (rdata !== q[0])
                $display("FAIL full_drain[%0d]: got %h want %h", i, rdata, q[0]);
            else n_pass++;
            step(0, 1, '0, 0, 0);
        end
        n_checks++;
        if (rdata !== 32'h12345678 || level !== 7'd1)
            $display("FAIL late_word: got rdata=%h level=%0d want 12345678/1", rdata, level);
        else n_pass++;
        step(0, 1, '0, 0, 0);
    endtask

    task automatic test_steady_wrap();
        for (int i = 0; i < 10; i++) step(1, 0, $urandom, 0, 0);
        for (int i = 0; i < 100; i++) begin
            n_checks++;
            if (rdata !== q[0])
                $display("FAIL steady_data[%0d]: got %h want %h", i, rdata, q[0]);
            else n_pass++;
            step(1, 1, $urandom, 0, 0);
            n_checks++;
            if ({level, status} !== {7'd10, 4'b0000})
                $display("FAIL steady_flags[%0d]: got level=%0d status=%b want 10/0000", i, level, status);
            else n_pass++;
        end
        while (q.size() > 0) step(0, 1, '0, 0, 0);
    endtask

    task automatic test_random();
        bit w;
        bit r;
        for (int i = 0; i < 600; i++) begin
            // Bias phases toward filling or draining so both boundaries are hit.
            if ((i / 100) % 2 == 0) begin
                w = ($urandom_range(0, 9) < 8); r = ($urandom_range(0, 9) < 3);
            end else begin
                w = ($urandom_range(0, 9) < 3); r = ($urandom_range(0, 9) < 8);
            end
            step(w, r, $urandom, 0, 0);
            n_checks++;
            if ({level, status} !== exp_flags())
                $display("FAIL random_flags[%0d]: got %b want %b", i, {level, status}, exp_flags());
            else n_pass++;
            if (q.size() > 0) begin
                n_checks++;
                if (rdata !== q[0])
                    $display("FAIL random_data[%0d]: got %h want %h", i, rdata, q[0]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_clear_preset();
        for (int pass = 0; pass < 2; pass++) begin
            while (q.size() < 20) step(1, 0, $urandom, 0, 0);
            while (q.size() > 20) step(0, 1, '0, 0, 0);
            step(1, 1, $urandom, pass == 0, pass == 1);
            n_checks++;
            if ({level, status} !== 11'b0000000_0100)
                $display("FAIL flush_%0s: got level=%0d status=%b want 0/0100",
                         pass == 0 ? "clear" : "preset", level, status);
            else n_pass++;
        end
        // Flushing a full FIFO with a push pending must not raise overflow.
        for (int i = 0; i < DEPTH; i++) step(1, 0, $urandom, 0, 0);
        step(1, 0, $urandom, 1, 0);
        n_checks++;
        if ({level, status} !== 11'b0000000_0100)
            $display("FAIL flush_full: got level=%0d status=%b want 0/0100", level, status);
        else n_pass++;
        // Flushing an empty FIFO with a pop pending must not raise underflow.
        step(0, 1, '0, 0, 1);
        n_checks++;
        if ({level, status} !== 11'b0000000_0100)
            $display("FAIL flush_empty_pop: got level=%0d status=%b want 0/0100", level, status);
        else n_pass++;
    endtask

    initial begin
        preset = 1; clear = 0; wen = 0; ren = 0; wdata = '0;
        exp_ovf = 0; exp_unf = 0;
        @(negedge pclk);
        test_reset();
        test_fill_overflow();
        test_fwft_underflow();
        test_full_push_pop();
        test_steady_wrap();
        test_random();
        test_clear_preset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_spi_fifo
